// File: rtl/bus_mon_pkg.sv
// Shared widths and the event record layout for the bus change monitor.
package bus_mon_pkg;
  localparam int DATA_W  = 16;
  localparam int STAMP_W = 32;
  localparam int DEPTH   = 8;

  typedef struct packed {
    logic [STAMP_W-1:0] stamp;
    logic [DATA_W-1:0]  data;
  } bus_event_t;
endpackage

// File: rtl/bus_change_monitor_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_q;
  // Zero while empty so the head reads as a clean value after reset.
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/bus_change_monitor.sv
// Records every change of a sampled bus as a {cycle stamp, data} event in a FIFO.
module bus_change_monitor #(
  parameter int DATA_W  = bus_mon_pkg::DATA_W,
  parameter int STAMP_W = bus_mon_pkg::STAMP_W,
  parameter int DEPTH   = bus_mon_pkg::DEPTH,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_en,
  input  logic [DATA_W-1:0]  bus_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [STAMP_W-1:0] out_stamp,
  output logic [CW-1:0]      count,
  output logic               overflow,
  input  logic               clr_overflow
);
  localparam int EW = STAMP_W + DATA_W;

  logic [STAMP_W-1:0] cyc_q, cyc_d;
  logic [DATA_W-1:0]  prev_q, prev_d;
  logic               primed_q, primed_d;
  logic               overflow_q, overflow_d;
  logic               is_event, pop, drop;
  logic               fifo_full, fifo_empty;
  logic [EW-1:0]      head;

  // Handshake: the head event transfers in any cycle where out_valid && out_ready;
  // while out_valid && !out_ready the head holds still; out_ready is ignored when
  // out_valid is low.
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign is_event  = sample_en && (!primed_q || (bus_data != prev_q));
  assign drop      = is_event && fifo_full && !pop;
  assign out_stamp = head[EW-1:DATA_W];
  assign out_data  = head[DATA_W-1:0];
  assign overflow  = overflow_q;

  always_comb begin
    cyc_d      = cyc_q + STAMP_W'(1);
    prev_d     = prev_q;
    primed_d   = primed_q;
    overflow_d = overflow_q;
    // prev tracks every enabled sample, dropped or not.
    if (sample_en) begin
      prev_d   = bus_data;
      primed_d = 1'b1;
    end
    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q      <= '0;
      prev_q     <= '0;
      primed_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      cyc_q      <= cyc_d;
      prev_q     <= prev_d;
      primed_q   <= primed_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (is_event && !drop),
    .pop   (pop),
    .wdata ({cyc_q, bus_data}),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_bus_change_monitor.sv
// Directed self-checking bench for bus_change_monitor with hand-computed events.
module tb_bus_change_monitor;
  import bus_mon_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_en;
  logic [DATA_W-1:0]  bus_data;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [STAMP_W-1:0] out_stamp;
  logic [3:0]         count;
  logic               overflow;
  logic               clr_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_change_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .sample_en    (sample_en),
    .bus_data     (bus_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_stamp    (out_stamp),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  // Drive one cycle's inputs, then land 1 time unit after the rising edge.
  task automatic drv(input logic en, input logic [DATA_W-1:0] d,
                     input logic rdy, input logic clr);
    sample_en    = en;
    bus_data     = d;
    out_ready    = rdy;
    clr_overflow = clr;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of cycle 0 (cyc=0) with rst released.
  task automatic reset_dut();
    rst = 1'b1;
    drv(1'b0, '0, 1'b0, 1'b0);
    drv(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid);
    end
    n_checks++;
    if (out_data !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0000", out_data);
    end
    n_checks++;
    if (out_stamp !== '0) begin
      n_fail++; $display("FAIL reset_stamp: got %0d want 0", out_stamp);
    end
    n_checks++;
    if (count !== 4'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", count);
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_overflow: got %0b want 0", overflow);
    end
  endtask

  task automatic test_first_and_change();
    reset_dut();
    repeat (3) drv(1'b0, '0, 1'b1, 1'b0);
    drv(1'b1, 16'h0000, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_stamp !== 32'd3) begin
      n_fail++;
      $display("FAIL first_event: got v=%0b d=%h s=%0d want v=1 d=0000 s=3", out_valid, out_data, out_stamp);
    end
    drv(1'b1, 16'hdead, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hdead || out_stamp !== 32'd4 || count !== 4'd1) begin
      n_fail++;
      $display("FAIL change_event: got v=%0b d=%h s=%0d c=%0d want v=1 d=dead s=4 c=1", out_valid, out_data, out_stamp, count);
    end
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 16'hdead, 1'b1, 1'b0);
      n_checks++;
      if (out_valid !== 1'b0 || count !== 4'd0) begin
        n_fail++;
        $display("FAIL repeat_no_event[%0d]: got v=%0b c=%0d want v=0 c=0", i, out_valid, count);
      end
    end
  endtask

  task automatic test_stall_and_drain();
    logic [DATA_W-1:0] v [4];
    v = '{16'hdead, 16'hbeef, 16'hface, 16'hcafe};
    reset_dut();
    repeat (10) drv(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drv(1'b1, v[i], 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd4) begin
      n_fail++; $display("FAIL stall_count: got %0d want 4", count);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 16'hdead || out_stamp !== 32'd10) begin
        n_fail++;
        $display("FAIL stall_head[%0d]: got v=%0b d=%h s=%0d want v=1 d=dead s=10", i, out_valid, out_data, out_stamp);
      end
      drv(1'b0, 16'h1234, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== v[i] || out_stamp !== STAMP_W'(10 + i)) begin
        n_fail++;
        $display("FAIL drain[%0d]: got v=%0b d=%h s=%0d want v=1 d=%h s=%0d", i, out_valid, out_data, out_stamp, v[i], 10 + i);
      end
      drv(1'b0, '0, 1'b1, 1'b0);
    end
    n_checks++;
    if (out_valid !== 1'b0 || count !== 4'd0) begin
      n_fail++; $display("FAIL drain_empty: got v=%0b c=%0d want v=0 c=0", out_valid, count);
    end
  endtask

  task automatic test_overflow();
    reset_dut();
    for (int i = 0; i < 9; i++) drv(1'b1, DATA_W'(16'h1000 + i), 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd8 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_full: got c=%0d o=%0b want c=8 o=1", count, overflow);
    end
    n_checks++;
    if (out_data !== 16'h1000 || out_stamp !== 32'd0) begin
      n_fail++; $display("FAIL ovf_head: got d=%h s=%0d want d=1000 s=0", out_data, out_stamp);
    end
    drv(1'b1, 16'h1009, 1'b0, 1'b1);
    n_checks++;
    if (overflow !== 1'b1 || count !== 4'd8) begin
      n_fail++; $display("FAIL ovf_drop_beats_clr: got o=%0b c=%0d want o=1 c=8", overflow, count);
    end
    drv(1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got %0b want 0", overflow);
    end
  endtask

  // Continues from a full FIFO left by test_overflow, now in cycle 11.
  task automatic test_full_push_pop();
    bus_event_t exp_ev;
    drv(1'b1, 16'h2000, 1'b1, 1'b0);
    n_checks++;
    if (count !== 4'd8 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_pp_count: got c=%0d o=%0b want c=8 o=0", count, overflow);
    end
    for (int i = 1; i <= 8; i++) begin
      exp_ev.stamp = (i == 8) ? STAMP_W'(11) : STAMP_W'(i);
      exp_ev.data  = (i == 8) ? 16'h2000 : DATA_W'(16'h1000 + i);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp_ev.data || out_stamp !== exp_ev.stamp) begin
        n_fail++;
        $display("FAIL full_pp_order[%0d]: got v=%0b d=%h s=%0d want v=1 d=%h s=%0d", i, out_valid, out_data, out_stamp, exp_ev.data, exp_ev.stamp);
      end
      drv(1'b0, '0, 1'b1, 1'b0);
    end
    n_checks++;
    if (out_valid !== 1'b0 || count !== 4'd0) begin
      n_fail++; $display("FAIL full_pp_empty: got v=%0b c=%0d want v=0 c=0", out_valid, count);
    end
  endtask

  task automatic test_sample_gate();
    reset_dut();
    drv(1'b1, 16'hface, 1'b0, 1'b0);
    drv(1'b1, 16'hcafe, 1'b0, 1'b0);
    for (int i = 2; i < 8; i++) drv(1'b0, (i % 2 == 1) ? 16'hface : 16'hcafe, 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd2) begin
      n_fail++; $display("FAIL gate_disabled: got c=%0d want 2", count);
    end
    drv(1'b1, 16'hcafe, 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd2) begin
      n_fail++; $display("FAIL gate_reenable_same: got c=%0d want 2", count);
    end
    drv(1'b1, 16'hface, 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd3 || out_data !== 16'hface || out_stamp !== 32'd0) begin
      n_fail++; $display("FAIL gate_new_event: got c=%0d d=%h s=%0d want c=3 d=face s=0", count, out_data, out_stamp);
    end
  endtask

  // Continues with three entries queued by test_sample_gate; last sample was face.
  task automatic test_reset_mid();
    rst = 1'b1;
    drv(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    n_checks++;
    if (count !== 4'd0 || out_valid !== 1'b0 || out_data !== '0 || out_stamp !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: got c=%0d v=%0b d=%h s=%0d want c=0 v=0 d=0000 s=0", count, out_valid, out_data, out_stamp);
    end
    drv(1'b0, '0, 1'b0, 1'b0);
    drv(1'b0, '0, 1'b0, 1'b0);
    drv(1'b1, 16'hface, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hface || out_stamp !== 32'd2 || count !== 4'd1) begin
      n_fail++;
      $display("FAIL mid_reset_reprime: got v=%0b d=%h s=%0d c=%0d want v=1 d=face s=2 c=1", out_valid, out_data, out_stamp, count);
    end
  endtask

  initial begin
    rst          = 1'b1;
    sample_en    = 1'b0;
    bus_data     = '0;
    out_ready    = 1'b0;
    clr_overflow = 1'b0;
    test_reset();
    test_first_and_change();
    test_stall_and_drain();
    test_overflow();
    test_full_push_pop();
    test_sample_gate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_change_monitor.md
Name: bus_change_monitor

Overview:
- Receive-side companion to the interface-driving test writers: samples a shared 16-bit data bus every enabled cycle and records each value change as an event.
- Each event is {cycle stamp, new data}, held in a small FIFO and drained by a consumer over a valid/ready handshake.
- Sits on the observing end of a bus interface and lets checkers confirm both what was written and in which cycle.

Parameters:
- DATA_W, 16, bus data width.
- STAMP_W, 32, free-running cycle-counter width; the counter wraps.
- DEPTH, 8, event FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- sample_en  input  1  bus_data is sampled this cycle.
- bus_data  input  DATA_W  observed bus value.
- out_valid  output  1  head event available.
- out_ready  input  1  consumer accepts the head event when out_valid=1.
- out_data  output  DATA_W  data field of the head event.
- out_stamp  output  STAMP_W  cycle stamp of the head event.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; set when an event is dropped.
- clr_overflow  input  1  clears overflow.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_stamp=0, count=0, overflow=0; internal prev=0, primed=0, cyc=0.
- cyc increments every cycle, wraps 2^STAMP_W-1 -> 0, and is not gated by sample_en.
- Event condition: sample_en && (!primed || bus_data != prev).
  - The first enabled sample after reset is always an event.
  - A sample equal to prev is never an event.
- On every enabled sample: prev <= bus_data, primed <= 1. This update happens even if the event is dropped.
- Event push: entry {cyc, bus_data} uses the cyc value of the sampling cycle.
- Latency: an event sampled in cycle N with the FIFO empty gives out_valid=1 in cycle N+1, with out_stamp=N.
- Handshake:
  - Pop occurs when out_valid && out_ready.
  - out_data and out_stamp stay stable while out_valid && !out_ready.
  - out_ready has no effect when out_valid=0.
- FIFO outputs are show-ahead: the head entry is driven directly.
- Occupancy rules:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged.
- Full boundary (count=DEPTH):
  - Event with simultaneous pop: the event is accepted.
  - Event without pop: the event is dropped, overflow <= 1, and FIFO contents are unchanged.
- Empty boundary: a push and a pop cannot coincide, because out_valid=0 when empty.
- overflow:
  - Set on any drop.
  - Cleared by clr_overflow.
  - A drop in the same cycle as clr_overflow wins, so overflow stays 1.
- Pointers: wrap modulo DEPTH; count saturates at exactly DEPTH and never exceeds it.
- Reset mid-operation:
  - All entries are discarded and primed clears.
  - The next enabled sample is recorded as an event even if it equals the pre-reset value.

Decomposition:
- Package bus_mon_pkg:
  - localparams DATA_W and STAMP_W defaults.
  - typedef struct packed {logic [STAMP_W-1:0] stamp; logic [DATA_W-1:0] data;} bus_event_t.
- One sub-module, sync_fifo, parameterised by entry width and DEPTH.
  - Ports: push, pop, wdata, rdata, count, full, empty.
  - Same clk and synchronous active-high rst.
- The top holds the cycle counter, change detector, overflow logic and handshake glue.

Test Plan:
- Reset, out_ready=1. Cycle 3: sample_en=1, bus_data=0000. Cycles 4-6: sample_en=1, bus_data=dead. Expect exactly two events: {3,0000} valid in cycle 4, and {4,dead} valid in cycle 5. No event for cycles 5-6.
- out_ready=0. Enabled samples dead, beef, face, cafe in cycles 10-13. Expect count=4 and head stable at {10,dead} while stalled. Then raise out_ready: pops come out in order dead, beef, face, cafe with stamps 10, 11, 12, 13.
- DEPTH=8, out_ready=0. Feed 9 distinct values. Expect count=8, overflow=1, and the 9th value absent. clr_overflow -> overflow=0.
- FIFO full. Drive an event together with out_ready=1. Expect the pop is accepted, the new event is stored, count stays 8, and overflow stays 0.
- sample_en=0 while bus_data toggles between face and cafe. Expect no events and prev unchanged. Re-enable with cafe when prev=cafe: no event.
- Assert rst with 3 entries queued, then release. Expect count=0 and out_valid=0. The next enabled sample, equal to the last pre-reset value, is recorded with a stamp counted from 0.
